ensamblador_bytes: RTL and testbench
====================================

Name: ensamblador_bytes

Overview:
- RX-side counterpart of the TX byte splitter.
- Pops bytes from the UART RX FIFO (first-word-fall-through) and packs every BYTES_X_PALABRA consecutive bytes into one TAM_DATA-bit word, first byte into the MSB, matching the TX splitter's MSB-first order.
- Presents each completed word to the debug/loader control unit with a valid/ack handshake.
- Discards stale partial words after an inter-byte timeout.

Parameters:
- TAM_DATA, 32, width of the assembled word; must be a multiple of 8.
- TIMEOUT_CICLOS, 1000000, idle cycles tolerated between bytes of one word; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_reset  in  1  reset, asynchronous, active-low (0 = reset).
- i_fifo_empty  in  1  RX FIFO empty flag.
- i_fifo_byte  in  8  RX FIFO head byte, valid whenever i_fifo_empty=0.
- o_rd_fifo  out  1  pop strobe to RX FIFO; combinational, one pop per high cycle.
- i_flush  in  1  synchronous clear of partial word and pending output.
- i_palabra_ack  in  1  consumer accepts o_palabra.
- o_palabra  out  TAM_DATA  assembled word, stable while o_palabra_valida=1.
- o_palabra_valida  out  1  word available; level, held until acked.
- o_timeout_error  out  1  one-cycle pulse when a partial word is dropped by timeout.
- o_bytes_recibidos  out  2  bytes held in the current partial word (debug).

Behaviour:
- Reset (i_reset=0, any time, asynchronous): state=ACUMULAR, shift register=0, byte count=0, timeout counter=0, o_palabra=0, o_palabra_valida=0, o_timeout_error=0, o_bytes_recibidos=0. A partial word in progress is lost; the FIFO is not touched.
- Two states: ACUMULAR and ENTREGAR.
- ACUMULAR:
  - o_rd_fifo = !i_fifo_empty && !i_flush.
  - On each pop: shift <= {shift[TAM_DATA-9:0], i_fifo_byte}; count++; timeout counter cleared.
  - On the pop that makes count = BYTES_X_PALABRA (4th byte): next edge loads o_palabra with the full word including that byte, sets o_palabra_valida=1, resets count to 0 and moves to ENTREGAR.
  - Latency: o_palabra_valida rises the cycle after the 4th pop.
- ENTREGAR:
  - o_rd_fifo=0; FIFO contents are left untouched.
  - On i_palabra_ack=1: o_palabra_valida=0 on the next edge, return to ACUMULAR.
  - Minimum cycle per word, with a continuously non-empty FIFO and ack tied high: 4 pops + 1 ENTREGAR cycle = 5 cycles.
- i_palabra_ack while o_palabra_valida=0 is ignored.
- Timeout (TIMEOUT_CICLOS>0), ACUMULAR with count>0 only:
  - The timeout counter increments on every cycle with no pop.
  - When it reaches TIMEOUT_CICLOS-1 and no pop occurs that cycle: count=0, shift=0, counter=0, o_timeout_error=1 for exactly one cycle.
  - With count=0 the counter is held at 0.
- Simultaneous pop and timeout expiry: the pop wins; the byte is accepted and the counter clears.
- i_flush=1 (synchronous, highest priority after reset):
  - Clears count, shift and timeout counter.
  - Drops o_palabra_valida and returns to ACUMULAR.
  - o_rd_fifo is forced to 0 that cycle; no error pulse.
- o_palabra keeps its last value after ack/flush; it is meaningful only while o_palabra_valida=1.
- o_bytes_recibidos = count; its width is $clog2(BYTES_X_PALABRA).

Decomposition:
- Shared include/package:
  - BITS_X_BYTE=8.
  - BYTES_X_PALABRA=TAM_DATA/8.
  - State encodings ACUMULAR=1'b0, ENTREGAR=1'b1, shared with the TX splitter's constants.
- One sub-module: contador_timeout.
  - Parameter TIMEOUT_CICLOS.
  - Inputs: i_clk, i_reset, i_clear, i_run.
  - Output: o_expired, a one-cycle pulse.
  - Its counter width is $clog2(TIMEOUT_CICLOS+1).
  - When TIMEOUT_CICLOS=0 it is replaced by a generate-constant o_expired=0.

Test Plan:
- Reset mid-operation:
  - Stimulus: push 2 bytes, assert i_reset=0 for 1 cycle, then push 11,22,33,44.
  - Required response: o_palabra=32'h11223344; no remnant of the first 2 bytes.
- Basic assembly:
  - Stimulus: FIFO holds 8'hDE,AD,BE,EF; i_palabra_ack tied 1.
  - Required response: o_rd_fifo high 4 consecutive cycles; o_palabra_valida high 1 cycle, the cycle after the 4th pop; o_palabra=32'hDEADBEEF.
- Backpressure:
  - Stimulus: 8 bytes 01..08 queued, ack held 0 for 10 cycles, then pulsed.
  - Required response: o_palabra=32'h01020304 stable for all 10 cycles; no pops during ENTREGAR; second word 32'h05060708 follows.
- Timeout:
  - Stimulus: TIMEOUT_CICLOS=16; push AA,BB, then idle 20 cycles, then push 01,02,03,04.
  - Required response: o_timeout_error pulses once, 16 cycles after the BB pop; next word is 32'h01020304.
- Pop on expiry cycle:
  - Stimulus: TIMEOUT_CICLOS=16; after 2 bytes, present the 3rd byte exactly on the expiry cycle.
  - Required response: no error pulse; word completes normally after the 4th byte.
- Flush:
  - Stimulus: i_flush during a partial word, and separately while o_palabra_valida=1.
  - Required response: count returns to 0 and o_palabra_valida=0 on the next edge; o_rd_fifo=0 in the flush cycle; no error pulse.

Source files
------------

// File: rtl/ensamblador_bytes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ensamblador_bytes_pkg
//  Description : Constants and state encoding shared by the UART byte
//                assembler (RX) and the byte splitter (TX).
//                BITS_X_BYTE     - bits per transferred byte
//                estado_t        - ACUMULAR (gathering bytes) / ENTREGAR
//                                  (word offered to the consumer)
//                bytes_x_palabra - bytes per TAM_DATA-bit word
//  Revision    : 1.0 - initial release
// ============================================================================
package ensamblador_bytes_pkg;

    localparam int BITS_X_BYTE = 8;

    typedef enum logic [0:0] {
        ACUMULAR = 1'b0,
        ENTREGAR = 1'b1
    } estado_t;

    function automatic int bytes_x_palabra(input int tam_data);
        return tam_data / BITS_X_BYTE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ensamblador_bytes_contador_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : contador_timeout
//  Description : Idle-cycle counter for the byte assembler.
//                i_clk     - system clock
//                i_reset   - asynchronous reset, active-low
//                i_clear   - synchronous clear of the count
//                i_run     - count this cycle
//                o_expired - one-cycle pulse on the run cycle in which the
//                            count sits at TIMEOUT_CICLOS-1 (count then
//                            restarts from 0)
//                TIMEOUT_CICLOS=0 removes the counter; o_expired is then 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    generate
        if (TIMEOUT_CICLOS == 0) begin : g_sin_timeout
            logic w_unused;
            assign w_unused  = ^{i_clk, i_reset, i_clear, i_run};
            assign o_expired = 1'b0;
        end else begin : g_con_timeout
            localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
            localparam logic [CW-1:0] c_LIMITE = CW'(TIMEOUT_CICLOS - 1);

            logic [CW-1:0] r_cuenta;
            logic          w_limite;

            assign w_limite  = (r_cuenta == c_LIMITE);
            assign o_expired = i_run && w_limite && !i_clear;

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    r_cuenta <= '0;
                end else if (i_clear || (i_run && w_limite)) begin
                    r_cuenta <= '0;
                end else if (i_run) begin
                    r_cuenta <= r_cuenta + CW'(1);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ensamblador_bytes.sv
`default_nettype none
// ============================================================================
//  Module      : ensamblador_bytes
//  Description : Pops bytes from a first-word-fall-through RX FIFO and packs
//                each group of BYTES_X_PALABRA bytes into one TAM_DATA word,
//                first byte in the MSBs. The word is offered with a
//                valid/ack handshake; stale partial words are dropped after
//                TIMEOUT_CICLOS idle cycles (0 disables the timeout).
//  Ports       : i_clk, i_reset (async, active-low)
//                i_fifo_empty, i_fifo_byte, o_rd_fifo   - RX FIFO side
//                i_flush                                - sync clear
//                o_palabra, o_palabra_valida, i_palabra_ack - consumer side
//                o_timeout_error   - one-cycle pulse on timeout drop
//                o_bytes_recibidos - bytes in current partial word
//  Revision    : 1.0 - initial release
// ============================================================================
module ensamblador_bytes
    import ensamblador_bytes_pkg::*;
#(
    parameter  int TAM_DATA        = 32,
    parameter  int TIMEOUT_CICLOS  = 1000000,
    localparam int BYTES_X_PALABRA = bytes_x_palabra(TAM_DATA),
    localparam int CNT_W           = $clog2(BYTES_X_PALABRA)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_fifo_empty,
    input  logic [7:0]          i_fifo_byte,
    output logic                o_rd_fifo,
    input  logic                i_flush,
    input  logic                i_palabra_ack,
    output logic [TAM_DATA-1:0] o_palabra,
    output logic                o_palabra_valida,
    output logic                o_timeout_error,
    output logic [CNT_W-1:0]    o_bytes_recibidos
);

    localparam logic [CNT_W-1:0] c_ULTIMO = CNT_W'(BYTES_X_PALABRA - 1);

    estado_t             r_estado;
    logic [TAM_DATA-1:0] r_shift;
    logic [TAM_DATA-1:0] r_palabra;
    logic [CNT_W-1:0]    r_cuenta;
    logic                r_valida;
    logic                r_error;

    logic                w_pop;
    logic                w_ultimo;
    logic [TAM_DATA-1:0] w_shift_sig;
    logic                w_run;
    logic                w_clear;
    logic                w_expired;

    assign w_pop       = (r_estado == ACUMULAR) && !i_fifo_empty && !i_flush;
    assign w_ultimo    = w_pop && (r_cuenta == c_ULTIMO);
    assign w_shift_sig = {r_shift[TAM_DATA-BITS_X_BYTE-1:0], i_fifo_byte};

    // The idle counter only runs while a partial word is waiting; any pop,
    // flush, empty word or delivery phase keeps it at zero. A pop on the
    // expiry cycle therefore wins over the timeout.
    assign w_clear = i_flush || w_pop || (r_cuenta == '0) || (r_estado != ACUMULAR);
    assign w_run   = !w_clear;

    contador_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_clear),
        .i_run     (w_run),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_estado  <= ACUMULAR;
            r_shift   <= '0;
            r_palabra <= '0;
            r_cuenta  <= '0;
            r_valida  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (i_flush) begin
                r_estado <= ACUMULAR;
                r_shift  <= '0;
                r_cuenta <= '0;
                r_valida <= 1'b0;
            end else begin
                case (r_estado)
                    ACUMULAR: begin
                        if (w_pop) begin
                            r_shift <= w_shift_sig;
                            if (w_ultimo) begin
                                r_palabra <= w_shift_sig;
                                r_valida  <= 1'b1;
                                r_cuenta  <= '0;
                                r_estado  <= ENTREGAR;
                            end else begin
                                r_cuenta <= r_cuenta + CNT_W'(1);
                            end
                        end else if (w_expired) begin
                            r_cuenta <= '0;
                            r_shift  <= '0;
                            r_error  <= 1'b1;
                        end
                    end
                    ENTREGAR: begin
                        if (i_palabra_ack) begin
                            r_valida <= 1'b0;
                            r_estado <= ACUMULAR;
                        end
                    end
                    default: r_estado <= ACUMULAR;
                endcase
            end
        end
    end

    assign o_rd_fifo         = w_pop;
    assign o_palabra         = r_palabra;
    assign o_palabra_valida  = r_valida;
    assign o_timeout_error   = r_error;
    assign o_bytes_recibidos = r_cuenta;

endmodule
`default_nettype wire

// File: tb/tb_ensamblador_bytes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ensamblador_bytes
//  Description : Self-checking bench for ensamblador_bytes (TAM_DATA=32,
//                TIMEOUT_CICLOS=16) with a queue-based FWFT FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ensamblador_bytes;

    localparam int TAM = 32;
    localparam int TO  = 16;

    logic           i_clk = 1'b0;
    logic           i_reset;
    logic           i_fifo_empty;
    logic [7:0]     i_fifo_byte;
    logic           o_rd_fifo;
    logic           i_flush;
    logic           i_palabra_ack;
    logic [TAM-1:0] o_palabra;
    logic           o_palabra_valida;
    logic           o_timeout_error;
    logic [1:0]     o_bytes_recibidos;

    ensamblador_bytes #(
        .TAM_DATA       (TAM),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_fifo_empty      (i_fifo_empty),
        .i_fifo_byte       (i_fifo_byte),
        .o_rd_fifo         (o_rd_fifo),
        .i_flush           (i_flush),
        .i_palabra_ack     (i_palabra_ack),
        .o_palabra         (o_palabra),
        .o_palabra_valida  (o_palabra_valida),
        .o_timeout_error   (o_timeout_error),
        .o_bytes_recibidos (o_bytes_recibidos)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic       rd_ult;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] palabra;
    } vec_t;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        i_fifo_empty = (q.size() == 0);
        i_fifo_byte  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        drive_fifo();
    endtask

    // One clock cycle: sample the pop strobe before the edge, retire the
    // FIFO head on the edge, then return just after the falling edge.
    task automatic step();
        #1;
        rd_ult = o_rd_fifo;
        @(posedge i_clk);
        if (rd_ult && q.size() != 0) void'(q.pop_front());
        @(negedge i_clk);
        drive_fifo();
        #1;
    endtask

    task automatic push4(input logic [7:0] a, b, c, d);
        push(a); push(b); push(c); push(d);
    endtask

    vec_t tabla[5];

    initial begin
        int pulsos;
        int pulso_en;

        tabla[0] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEADBEEF};
        tabla[1] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h00000001};
        tabla[2] = '{8'h80, 8'h00, 8'h00, 8'h00, 32'h80000000};
        tabla[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
        tabla[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h12345678};

        i_reset       = 1'b0;
        i_flush       = 1'b0;
        i_palabra_ack = 1'b0;
        drive_fifo();
        @(negedge i_clk);
        #1;
        chk("rst_valida",  {31'b0, o_palabra_valida}, 32'd0);
        chk("rst_palabra", o_palabra, 32'd0);
        chk("rst_bytes",   {30'b0, o_bytes_recibidos}, 32'd0);
        chk("rst_error",   {31'b0, o_timeout_error}, 32'd0);
        step();
        i_reset = 1'b1;
        step();

        // ---- table-driven basic assembly, ack tied high ----
        i_palabra_ack = 1'b1;
        for (int v = 0; v < 5; v++) begin
            push4(tabla[v].b0, tabla[v].b1, tabla[v].b2, tabla[v].b3);
            for (int k = 0; k < 4; k++) begin
                step();
                chk("tab_pop", {31'b0, rd_ult}, 32'd1);
                if (k < 3) chk("tab_valida_antes", {31'b0, o_palabra_valida}, 32'd0);
            end
            chk("tab_valida",  {31'b0, o_palabra_valida}, 32'd1);
            chk("tab_palabra", o_palabra, tabla[v].palabra);
            chk("tab_bytes",   {30'b0, o_bytes_recibidos}, 32'd0);
            step();
            chk("tab_valida_1ciclo", {31'b0, o_palabra_valida}, 32'd0);
        end

        // ---- backpressure ----
        i_palabra_ack = 1'b0;
        push4(8'h01, 8'h02, 8'h03, 8'h04);
        push4(8'h05, 8'h06, 8'h07, 8'h08);
        for (int k = 0; k < 4; k++) step();
        chk("bp_valida",  {31'b0, o_palabra_valida}, 32'd1);
        chk("bp_palabra", o_palabra, 32'h01020304);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_estable",  o_palabra, 32'h01020304);
            chk("bp_valida_h", {31'b0, o_palabra_valida}, 32'd1);
            chk("bp_sin_pop",  {31'b0, rd_ult}, 32'd0);
            chk("bp_fifo",     q.size(), 32'd4);
        end
        i_palabra_ack = 1'b1;
        step();
        chk("bp_ack", {31'b0, o_palabra_valida}, 32'd0);
        i_palabra_ack = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("bp_valida2",  {31'b0, o_palabra_valida}, 32'd1);
        chk("bp_palabra2", o_palabra, 32'h05060708);
        i_palabra_ack = 1'b1;
        step();

        // ---- timeout: error pulse 16 edges after the BB pop ----
        push(8'hAA); push(8'hBB);
        step(); step();
        chk("to_bytes2", {30'b0, o_bytes_recibidos}, 32'd2);
        pulsos   = 0;
        pulso_en = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (o_timeout_error) begin
                pulsos++;
                pulso_en = i;
            end
            if (i == 15) chk("to_bytes_antes", {30'b0, o_bytes_recibidos}, 32'd2);
        end
        chk("to_pulsos",   pulsos, 32'd1);
        chk("to_ciclo",    pulso_en, 32'd16);
        chk("to_bytes0",   {30'b0, o_bytes_recibidos}, 32'd0);
        push4(8'h01, 8'h02, 8'h03, 8'h04);
        for (int k = 0; k < 4; k++) step();
        chk("to_palabra", o_palabra, 32'h01020304);
        chk("to_valida",  {31'b0, o_palabra_valida}, 32'd1);
        step();

        // ---- pop on the expiry cycle wins over the timeout ----
        push(8'hA1); push(8'hA2);
        step(); step();
        pulsos = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (o_timeout_error) pulsos++;
        end
        push(8'hA3);
        step();
        if (o_timeout_error) pulsos++;
        chk("exp_bytes3", {30'b0, o_bytes_recibidos}, 32'd3);
        push(8'hA4);
        step();
        if (o_timeout_error) pulsos++;
        chk("exp_sin_error", pulsos, 32'd0);
        chk("exp_valida",    {31'b0, o_palabra_valida}, 32'd1);
        chk("exp_palabra",   o_palabra, 32'hA1A2A3A4);
        step();

        // ---- flush during a partial word ----
        push(8'hC1); push(8'hC2);
        step(); step();
        push(8'hC3);
        i_flush = 1'b1;
        #1;
        chk("fl_rd", {31'b0, o_rd_fifo}, 32'd0);
        step();
        chk("fl_bytes", {30'b0, o_bytes_recibidos}, 32'd0);
        chk("fl_error", {31'b0, o_timeout_error}, 32'd0);
        chk("fl_fifo",  q.size(), 32'd1);
        i_flush = 1'b0;
        push(8'hD1); push(8'hD2); push(8'hD3);
        for (int k = 0; k < 4; k++) step();
        chk("fl_palabra", o_palabra, 32'hC3D1D2D3);
        step();

        // ---- flush while a word is pending ----
        i_palabra_ack = 1'b0;
        push4(8'hE1, 8'hE2, 8'hE3, 8'hE4);
        for (int k = 0; k < 4; k++) step();
        chk("flv_valida", {31'b0, o_palabra_valida}, 32'd1);
        i_flush = 1'b1;
        step();
        chk("flv_valida0", {31'b0, o_palabra_valida}, 32'd0);
        chk("flv_bytes",   {30'b0, o_bytes_recibidos}, 32'd0);
        chk("flv_error",   {31'b0, o_timeout_error}, 32'd0);
        i_flush       = 1'b0;
        i_palabra_ack = 1'b1;
        step();
        chk("flv_ack_ign", {31'b0, o_palabra_valida}, 32'd0);

        // ---- reset in the middle of a word ----
        push(8'h55); push(8'h66);
        step(); step();
        chk("rm_bytes2", {30'b0, o_bytes_recibidos}, 32'd2);
        i_reset = 1'b0;
        #1;
        chk("rm_bytes0",   {30'b0, o_bytes_recibidos}, 32'd0);
        chk("rm_palabra0", o_palabra, 32'd0);
        step();
        i_reset = 1'b1;
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        for (int k = 0; k < 4; k++) step();
        chk("rm_valida",  {31'b0, o_palabra_valida}, 32'd1);
        chk("rm_palabra", o_palabra, 32'h11223344);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
